// File: rtl/reg_file_pkg.sv
// Shared defaults and write-port numbering for the multi-port register file.
package reg_file_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int WP_ALU     = 0;
  localparam int WP_LOAD    = 1;
  localparam int NUM_WP     = 2;
endpackage

// File: rtl/reg_file_mp_if.sv
// Register-file access bundle: two read ports, two write ports and the issue marker.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [ADDR_W-1:0] RN1;
  logic [ADDR_W-1:0] RN2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic              BUSY1;
  logic              BUSY2;
  logic              RegWrite0;
  logic [ADDR_W-1:0] WN0;
  logic [DATA_W-1:0] WD0;
  logic              RegWrite1;
  logic [ADDR_W-1:0] WN1;
  logic [DATA_W-1:0] WD1;
  logic              Issue;
  logic [ADDR_W-1:0] IN;

  modport master (
    output RN1, RN2, RegWrite0, WN0, WD0, RegWrite1, WN1, WD1, Issue, IN,
    input  RD1, RD2, BUSY1, BUSY2
  );

  modport slave (
    input  RN1, RN2, RegWrite0, WN0, WD0, RegWrite1, WN1, WD1, Issue, IN,
    output RD1, RD2, BUSY1, BUSY2
  );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write busy bits: issue sets, commit clears, issue beats a same-cycle commit.
// One-cycle update, registered output; never stalls.
module reg_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue,
  input  logic [ADDR_W-1:0]      issue_idx,
  input  logic [1:0]             clr_vld,
  input  logic [1:0][ADDR_W-1:0] clr_idx,
  output logic [2**ADDR_W-1:0]   busy
);
  logic [2**ADDR_W-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < 2; p++) begin
      if (clr_vld[p]) busy_nxt[clr_idx[p]] = 1'b0;
    end
    // New producer takes the register even if the old one retires this cycle.
    if (issue) busy_nxt[issue_idx] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end
endmodule

// File: rtl/reg_file_mp.sv
// Two-read/two-write register file with busy scoreboard; reads combinational, writes land at the edge.
// REG_FILE_MP_BYPASS_EN forwards same-cycle write data to the read ports; no backpressure.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  rf
);
  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0]            regs [NREG];
  logic [NUM_WP-1:0]            wr_en;
  logic [NUM_WP-1:0]            wr_ok;
  logic [NUM_WP-1:0][ADDR_W-1:0] wr_idx;
  logic [NUM_WP-1:0][DATA_W-1:0] wr_dat;
  logic [1:0][ADDR_W-1:0]       rd_idx;
  logic [1:0][DATA_W-1:0]       rd_dat;
  logic [NREG-1:0]              busy;

  assign wr_en[WP_ALU]   = rf.RegWrite0;
  assign wr_idx[WP_ALU]  = rf.WN0;
  assign wr_dat[WP_ALU]  = rf.WD0;
  assign wr_en[WP_LOAD]  = rf.RegWrite1;
  assign wr_idx[WP_LOAD] = rf.WN1;
  assign wr_dat[WP_LOAD] = rf.WD1;

  always_comb begin
    for (int p = 0; p < NUM_WP; p++) begin
      wr_ok[p] = wr_en[p] && !((ZERO_REG != 0) && (wr_idx[p] == '0));
    end
  end

  // Port order in the loop gives the load port the last word on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_WP; p++) begin
        if (wr_ok[p]) regs[wr_idx[p]] <= wr_dat[p];
      end
    end
  end

  assign rd_idx[0] = rf.RN1;
  assign rd_idx[1] = rf.RN2;

  always_comb begin
    rd_dat = '0;
    for (int r = 0; r < 2; r++) begin
      rd_dat[r] = regs[rd_idx[r]];
`ifdef REG_FILE_MP_BYPASS_EN
      if (!rst) begin
        for (int p = 0; p < NUM_WP; p++) begin
          if (wr_ok[p] && (wr_idx[p] == rd_idx[r])) rd_dat[r] = wr_dat[p];
        end
      end
`endif
      if ((ZERO_REG != 0) && (rd_idx[r] == '0)) rd_dat[r] = '0;
    end
  end

  assign rf.RD1   = rd_dat[0];
  assign rf.RD2   = rd_dat[1];
  assign rf.BUSY1 = busy[rf.RN1];
  assign rf.BUSY2 = busy[rf.RN2];

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .issue     (rf.Issue),
    .issue_idx (rf.IN),
    .clr_vld   (wr_en),
    .clr_idx   (wr_idx),
    .busy      (busy)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and random checks of reg_file_mp against an array-based reference model.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] m_regs [NR];
  logic          m_busy [NR];

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (bus.slave)
  );

  task automatic idle();
    bus.RegWrite0 = 1'b0; bus.WN0 = '0; bus.WD0 = '0;
    bus.RegWrite1 = 1'b0; bus.WN1 = '0; bus.WD1 = '0;
    bus.Issue = 1'b0; bus.IN = '0;
  endtask

  // Reference state update applied at each rising edge from the inputs present then.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    end else begin
      if (bus.RegWrite0) m_busy[bus.WN0] = 1'b0;
      if (bus.RegWrite1) m_busy[bus.WN1] = 1'b0;
      if (bus.Issue) m_busy[bus.IN] = 1'b1;
      if (bus.RegWrite0 && bus.WN0 != 0) m_regs[bus.WN0] = bus.WD0;
      if (bus.RegWrite1 && bus.WN1 != 0) m_regs[bus.WN1] = bus.WD1;
      m_busy[0] = 1'b0;
    end
    #1;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] rn);
    if (rn == 0) return '0;
`ifdef REG_FILE_MP_BYPASS_EN
    if (!rst) begin
      if (bus.RegWrite1 && bus.WN1 == rn) return bus.WD1;
      if (bus.RegWrite0 && bus.WN0 == rn) return bus.WD0;
    end
`endif
    return m_regs[rn];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".RD1"}, bus.RD1, exp_rd(bus.RN1));
    check({tag, ".RD2"}, bus.RD2, exp_rd(bus.RN2));
    check({tag, ".BUSY1"}, {31'd0, bus.BUSY1}, {31'd0, (bus.RN1 != 0) && m_busy[bus.RN1]});
    check({tag, ".BUSY2"}, {31'd0, bus.BUSY2}, {31'd0, (bus.RN2 != 0) && m_busy[bus.RN2]});
  endtask

  initial begin
    logic [DW-1:0] r4_old;
    idle();
    bus.RN1 = '0; bus.RN2 = '0;
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;

    for (int i = 0; i < NR; i++) begin
      bus.RN1 = AW'(i); bus.RN2 = AW'(NR - 1 - i); #1;
      check("reset_sweep", bus.RD1, 32'd0);
      check("reset_busy", {31'd0, bus.BUSY1 | bus.BUSY2}, 32'd0);
    end

    // Reset wipes a just-written register
    bus.RegWrite0 = 1'b1; bus.WN0 = 5'd5; bus.WD0 = 32'hDEADBEEF; cycle();
    idle(); bus.RN1 = 5'd5; #1;
    check("pre_reset_r5", bus.RD1, 32'hDEADBEEF);
    rst = 1'b1; bus.RegWrite0 = 1'b1; bus.WN0 = 5'd5; bus.WD0 = 32'hCAFEF00D;
    bus.Issue = 1'b1; bus.IN = 5'd5; cycle();
    rst = 1'b0; idle(); #1;
    check("reset_r5", bus.RD1, 32'd0);
    check("reset_busy5", {31'd0, bus.BUSY1}, 32'd0);

    // Basic write then read
    bus.RegWrite0 = 1'b1; bus.WN0 = 5'd3; bus.WD0 = 32'h12345678; cycle();
    idle(); bus.RN2 = 5'd3; #1;
    check("write_r3", bus.RD2, 32'h12345678);

    // Both ports to r7: load port wins
    bus.RegWrite0 = 1'b1; bus.WN0 = 5'd7; bus.WD0 = 32'h1;
    bus.RegWrite1 = 1'b1; bus.WN1 = 5'd7; bus.WD1 = 32'h2; cycle();
    idle(); bus.RN1 = 5'd7; #1;
    check("conflict_r7", bus.RD1, 32'h2);

    // r0 stays zero and never busy
    bus.RegWrite0 = 1'b1; bus.WN0 = 5'd0; bus.WD0 = 32'hFFFFFFFF;
    bus.Issue = 1'b1; bus.IN = 5'd0; cycle();
    idle(); bus.RN1 = 5'd0; #1;
    check("zero_rd", bus.RD1, 32'd0);
    check("zero_busy", {31'd0, bus.BUSY1}, 32'd0);

    // Scoreboard sequence on r9
    bus.Issue = 1'b1; bus.IN = 5'd9; cycle();
    idle(); bus.RN1 = 5'd9; #1;
    check("sb_issue", {31'd0, bus.BUSY1}, 32'd1);
    bus.RegWrite1 = 1'b1; bus.WN1 = 5'd9; bus.WD1 = 32'h55;
    bus.Issue = 1'b1; bus.IN = 5'd9; #1;
    check("sb_no_early_clear", {31'd0, bus.BUSY1}, 32'd1);
    cycle();
    idle(); #1;
    check("sb_reissue", {31'd0, bus.BUSY1}, 32'd1);
    check("sb_data", bus.RD1, 32'h55);
    bus.RegWrite1 = 1'b1; bus.WN1 = 5'd9; bus.WD1 = 32'h66; cycle();
    idle(); #1;
    check("sb_clear", {31'd0, bus.BUSY1}, 32'd0);

    // Same-cycle read of a register being written
    bus.RegWrite0 = 1'b1; bus.WN0 = 5'd4; bus.WD0 = 32'h11111111; cycle();
    r4_old = 32'h11111111;
    bus.WD0 = 32'hA5A5A5A5; bus.RN1 = 5'd4; #1;
`ifdef REG_FILE_MP_BYPASS_EN
    check("bypass_r4", bus.RD1, 32'hA5A5A5A5);
`else
    check("bypass_r4", bus.RD1, r4_old);
`endif
    cycle();
    idle(); #1;
    check("after_r4", bus.RD1, 32'hA5A5A5A5);

    // Random traffic, occasional reset
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 24) == 0);
      bus.RegWrite0 = $urandom_range(0, 1) == 1;
      bus.WN0 = AW'($urandom_range(0, 7));
      bus.WD0 = $urandom;
      bus.RegWrite1 = $urandom_range(0, 2) == 0;
      bus.WN1 = AW'($urandom_range(0, 7));
      bus.WD1 = $urandom;
      bus.Issue = $urandom_range(0, 1) == 1;
      bus.IN = AW'($urandom_range(0, 7));
      bus.RN1 = AW'($urandom_range(0, 7));
      bus.RN2 = AW'($urandom_range(0, 7));
      #1;
      check_model("rand");
      cycle();
    end
    rst = 1'b0;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
